// File: rtl/gate_test_ctrl_pkg.sv
// Shared encodings for the board-level gate test sequencer.
package gate_test_ctrl_pkg;
  localparam int VEC_W = 2;

  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_e;

  typedef enum logic {
    S_SHOW = 1'b0,
    S_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/gate_test_ctrl_btn_debounce.sv
// One active-low button: 2-flop synchronizer, debounce counter, stable level
// and a single-cycle press pulse on an accepted 1->0 transition.
module btn_debounce
  import gate_test_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_but,
  output logic o_press
);
  logic [1:0]  r_sync;
  logic        r_stable;
  logic [15:0] r_cnt;
  logic        w_diff;
  logic        w_accept;

  assign w_diff   = r_sync[1] ^ r_stable;
  assign w_accept = w_diff && (r_cnt == DEBOUNCE_CYCLES - 16'd1);
  // Pulse only when the newly accepted level is "pressed"
  assign o_press  = w_accept && !r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], i_but};
      if (w_accept) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/gate_test_ctrl.sv
// Gate test sequencer: debounced buttons step the operand vector and the
// displayed gate; LEDs alternate between mode code and result/heartbeat.
// Optional auto-stepping of the operand vector: GATE_TEST_AUTO_STEP_EN.
module gate_test_ctrl
  import gate_test_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] SHOW_CYCLES     = 24'd6000000,
  parameter logic [23:0] HB_CYCLES       = 24'd3000000,
  parameter logic [23:0] AUTO_PERIOD     = 24'd12000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] but,
  output logic [1:0] led,
  output logic       gate_a,
  output logic       gate_b,
  input  logic [3:0] gate_y
);
  logic [1:0]       w_press;
  state_e           r_state, w_state_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic [VEC_W-1:0] r_vec, w_vec_nxt;
  logic [23:0]      r_timer, w_timer_nxt;
  logic [23:0]      r_hb_cnt, w_hb_cnt_nxt;
  logic             r_hb, w_hb_nxt;
  logic [1:0]       r_led, w_led_nxt;
  logic             w_step;

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_but  (but[gi]),
      .o_press(w_press[gi])
    );
  end

`ifdef GATE_TEST_AUTO_STEP_EN
  logic [23:0] r_auto, w_auto_nxt;
  logic        w_auto_tick;

  assign w_auto_tick = (r_state == S_RUN) && (r_auto == AUTO_PERIOD - 24'd1);
  // A manual step restarts the period; a coincident tick does not double-step
  assign w_auto_nxt  = (r_state != S_RUN || w_press[0] || w_auto_tick) ? '0 : r_auto + 24'd1;
  assign w_step      = w_press[0] | w_auto_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_auto <= '0;
    else        r_auto <= w_auto_nxt;
  end
`else
  logic [23:0] w_unused_auto;
  assign w_unused_auto = AUTO_PERIOD;
  assign w_step        = w_press[0];
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_timer_nxt  = r_timer;
    w_hb_cnt_nxt = '0;
    w_hb_nxt     = 1'b0;
    w_led_nxt    = r_led;
    w_vec_nxt    = w_step ? r_vec + 2'd1 : r_vec;
    case (r_state)
      S_SHOW: begin
        w_led_nxt = r_mode;
        if (r_timer == SHOW_CYCLES - 24'd1) begin
          w_state_nxt = S_RUN;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end
      S_RUN: begin
        w_led_nxt   = {r_hb, gate_y[r_mode]};
        w_timer_nxt = '0;
        if (r_hb_cnt == HB_CYCLES - 24'd1) begin
          w_hb_nxt     = ~r_hb;
          w_hb_cnt_nxt = '0;
        end else begin
          w_hb_nxt     = r_hb;
          w_hb_cnt_nxt = r_hb_cnt + 24'd1;
        end
      end
      default: w_state_nxt = S_SHOW;
    endcase
    // Mode change wins over any display timing and restarts the mode display
    if (w_press[1]) begin
      w_mode_nxt  = r_mode + 2'd1;
      w_state_nxt = S_SHOW;
      w_timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SHOW;
      r_mode   <= '0;
      r_vec    <= '0;
      r_timer  <= '0;
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
      r_led    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_vec    <= w_vec_nxt;
      r_timer  <= w_timer_nxt;
      r_hb_cnt <= w_hb_cnt_nxt;
      r_hb     <= w_hb_nxt;
      r_led    <= w_led_nxt;
    end
  end

  assign led    = r_led;
  assign gate_a = r_vec[1];
  assign gate_b = r_vec[0];
endmodule

// File: tb/tb_gate_test_ctrl.sv
// Bench for gate_test_ctrl: directed table of button steps plus random button
// activity, all checked every cycle against a timeline-based reference model.
module tb_gate_test_ctrl;
  localparam int DEB  = 4;
  localparam int SHOW = 8;
  localparam int HB   = 4;
  localparam int AUTO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] but = 2'b11;
  logic [1:0] led;
  logic       gate_a, gate_b;
  logic [3:0] gate_y;

  always #5 clk = ~clk;

  // Gates under test as they sit on the board
  assign gate_y = {~(gate_a & gate_b), gate_a ^ gate_b, gate_a | gate_b, gate_a & gate_b};

  gate_test_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .SHOW_CYCLES    (24'd8),
    .HB_CYCLES      (24'd4),
    .AUTO_PERIOD    (24'd16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .but   (but),
    .led   (led),
    .gate_a(gate_a),
    .gate_b(gate_b),
    .gate_y(gate_y)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_n = clock edges since the mode display last (re)started.
  int         m_vec, m_mode, m_n, m_auto;
  logic [1:0] m_led;
  logic [1:0] m_stable;
  logic [1:0] hist [0:7];  // hist[i] = button pins sampled i edges ago

  function automatic int gate_fn(input int mode, input int vec);
    int a, b;
    a = (vec >> 1) & 1;
    b = vec & 1;
    case (mode)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return (a & b) ^ 1;
    endcase
  endfunction

  task automatic model_reset();
    m_vec = 0; m_mode = 0; m_n = 0; m_auto = 0;
    m_led = 2'b00; m_stable = 2'b11;
    for (int i = 0; i < 8; i++) hist[i] = 2'b11;
  endtask

  task automatic model_edge();
    logic [1:0] p;
    logic       all_diff, run, tick;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = but;
    // A level is accepted once DEB consecutive synchronized samples disagree
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int i = 2; i < DEB + 2; i++)
        if (hist[i][b] == m_stable[b]) all_diff = 1'b0;
      p[b] = 1'b0;
      if (all_diff) begin
        m_stable[b] = ~m_stable[b];
        p[b] = (m_stable[b] == 1'b0);
      end
    end
    run = (m_n >= SHOW);
    if (!run) m_led = 2'(m_mode);
    else      m_led = {1'((((m_n - SHOW) / HB) % 2)), 1'(gate_fn(m_mode, m_vec))};
    tick = 1'b0;
`ifdef GATE_TEST_AUTO_STEP_EN
    tick   = run && (m_auto == AUTO - 1);
    m_auto = (!run || p[0] || tick) ? 0 : m_auto + 1;
`endif
    if (p[0] || tick) m_vec = (m_vec + 1) % 4;
    if (p[1]) begin
      m_mode = (m_mode + 1) % 4;
      m_n    = 0;
    end else begin
      m_n = m_n + 1;
    end
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [1:0] mv;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    @(negedge clk);
    mv = 2'(m_vec);
    check("model_led", led, m_led);
    check("model_ab", {gate_a, gate_b}, mv);
  endtask

  typedef struct {
    logic [1:0] b;
    int         hold;
    logic       rst;
    logic [1:0] exp_ab;
    logic [1:0] exp_led;
    logic [1:0] led_mask;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] b, input int hold, input logic rst,
                              input logic [1:0] ab, input logic [1:0] l, input logic [1:0] m);
    vec_t v;
    v.b = b; v.hold = hold; v.rst = rst; v.exp_ab = ab; v.exp_led = l; v.led_mask = m;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [1:0] ab0;
    int         hold;

    // Press on but[0] then reset in the middle of operation
    tbl.push_back(mk(2'b10, 4, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 2, 1, 2'b00, 2'b00, 2'b11));
    // Mode 0 display then run with heartbeat
    tbl.push_back(mk(2'b11, 8, 0, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 1, 0, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 4, 0, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk(2'b11, 4, 0, 2'b00, 2'b00, 2'b11));
    // Glitch rejected, then a long press steps once
    tbl.push_back(mk(2'b10, 3, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 10, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b10, 10, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 10, 0, 2'b01, 2'b00, 2'b01));
    // Vector wrap in AND mode
    tbl.push_back(mk(2'b10, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b10, 2'b00, 2'b01));
    tbl.push_back(mk(2'b10, 4, 0, 2'b10, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b11, 2'b01, 2'b01));
    tbl.push_back(mk(2'b10, 4, 0, 2'b11, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk(2'b10, 4, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b00, 2'b00));
    // Mode presses; the second lands inside the display and restarts it
    tbl.push_back(mk(2'b01, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b01, 2'b11));
    tbl.push_back(mk(2'b01, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b10, 2'b11));
    tbl.push_back(mk(2'b11, 5, 0, 2'b01, 2'b10, 2'b11));
    tbl.push_back(mk(2'b01, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b11, 2'b11));
    // NAND with vec=10 once running
    tbl.push_back(mk(2'b10, 4, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b10, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b10, 2'b01, 2'b01));
    // Simultaneous presses from a fresh reset
    tbl.push_back(mk(2'b11, 2, 1, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk(2'b00, 4, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 4, 0, 2'b01, 2'b01, 2'b11));
    tbl.push_back(mk(2'b11, 3, 0, 2'b01, 2'b01, 2'b11));

    model_reset();
    rst_n = 1'b0;
    but   = 2'b11;
    repeat (3) tick();
    check("reset_led", led, 2'b00);
    check("reset_ab", {gate_a, gate_b}, 2'b00);
    rst_n = 1'b1;

    foreach (tbl[r]) begin
      rst_n = !tbl[r].rst;
      but   = tbl[r].b;
      repeat (tbl[r].hold) tick();
      check($sformatf("row%0d_ab", r), {gate_a, gate_b}, tbl[r].exp_ab);
      check($sformatf("row%0d_led", r), led & tbl[r].led_mask, tbl[r].exp_led & tbl[r].led_mask);
    end
    rst_n = 1'b1;

    // Random button activity with occasional resets
    for (int k = 0; k < 300; k++) begin
      but  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
      hold = $urandom_range(1, 10);
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      repeat (hold) tick();
      rst_n = 1'b1;
    end

    // Idle window: only the auto-step (when built in) may move the vector
    but = 2'b11;
    repeat (12) tick();
    ab0 = {gate_a, gate_b};
    ab0 = 2'(m_vec);
    repeat (100) tick();
`ifndef GATE_TEST_AUTO_STEP_EN
    check("idle_no_step", {gate_a, gate_b}, ab0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_test_ctrl.md
Name: gate_test_ctrl

Overview:
- Sequences the board-level gate test.
- Debounces the two active-low buttons and steps a 2-bit input vector into the gates under test.
- Selects which gate result (AND/OR/XOR/NAND) is shown, and time-shares the two LEDs between a mode display and a result/heartbeat display.
- Sits between the board pins (but, led) and the gate instances inside the Hack top level.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000: consecutive cycles a synchronized button level must differ from its stable level before it is accepted.
- SHOW_CYCLES, 24'd6000000: cycles the mode code stays on the LEDs after a mode change.
- HB_CYCLES, 24'd3000000: heartbeat half-period in cycles.
- AUTO_PERIOD, 24'd12000000: auto-step period; used only with GATE_TEST_AUTO_STEP_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- but  input  2  raw buttons; 0 = pressed, 1 = released; asynchronous to clk.
- led  output  2  LEDs; 1 = on; registered.
- gate_a  output  1  operand A to gates under test; registered.
- gate_b  output  1  operand B to gates under test; registered.
- gate_y  input  4  gate results: [0]=AND, [1]=OR, [2]=XOR, [3]=NAND; combinational from gate_a/gate_b.

Behaviour:
- Reset (rst_n=0, asynchronous, all registers):
  - led=2'b00, gate_a=0, gate_b=0, mode=0, vec=0, state=S_SHOW.
  - All timers and debounce counters 0.
  - Synchronizer and stable button levels = 1 (released).
  - Reset mid-press or mid-display aborts everything; no press pulse is generated after release of reset unless a new qualified press occurs.
- Synchronizer: 2 flops per button bit.
- Debounce, per button:
  - When the synchronized level differs from the stable level, a counter increments.
  - When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronized level and the counter clears.
  - Any cycle where the levels match clears the counter.
  - A press pulse (1 cycle) is generated on a stable 1->0 transition only; release produces no pulse.
- Pulse use:
  - press[0] increments vec, wrapping 2'b11 -> 2'b00. gate_a=vec[1], gate_b=vec[0].
  - press[1] increments mode, wrapping 3 -> 0.
- FSM:
  - S_SHOW: led = mode (2-bit code). Timer counts to SHOW_CYCLES-1, then the state goes to S_RUN and the timer clears.
  - S_RUN: led[0] = gate_y[mode], registered. led[1] = heartbeat, toggling every HB_CYCLES; the heartbeat restarts at 0 on entry to S_RUN.
  - press[1] in any state: mode+1, state goes to S_SHOW, timer clears. This also applies during S_SHOW, where the display restarts.
  - press[0] in S_SHOW: vec advances and the state and timer are unchanged.
- Simultaneous press[0] and press[1] in the same cycle: both take effect (vec+1, mode+1, enter S_SHOW).
- Latency:
  - Raw press to pulse: 2 sync cycles + DEBOUNCE_CYCLES, ±1.
  - Pulse to gate_a/gate_b: 1 cycle.
  - gate_a/gate_b to led[0] in S_RUN: 1 cycle.

Optional Feature:
- Macro GATE_TEST_AUTO_STEP_EN.
- Defined: an auto timer counts to AUTO_PERIOD-1 in S_RUN and advances vec as if press[0] had occurred, then clears.
  - The timer is held at 0 in S_SHOW.
  - The timer clears on any manual press[0].
  - An auto-step coinciding with a manual press[0] advances vec by 1, not 2.
- Not defined: no auto timer logic; vec changes only on press[0].

Decomposition:
- Shared package/include:
  - Mode encodings: MODE_AND=0, MODE_OR=1, MODE_XOR=2, MODE_NAND=3.
  - State encodings: S_SHOW=0, S_RUN=1.
  - Vector width constant 2.
- Sub-module btn_debounce (one button: synchronizer, debounce counter, stable level, press pulse), instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4, SHOW_CYCLES=8, HB_CYCLES=4, AUTO_PERIOD=16; gate model tied to gate_y):
- Reset and display cycle:
  - Stimulus: assert rst_n=0 mid-operation, release, no presses.
  - Required: led=00 held 8 cycles (mode 0), then S_RUN.
  - Required: led[0]=AND(0,0)=0 and led[1] toggles every 4 cycles starting 0.
- Debounce glitch rejection:
  - Stimulus: but[0] low for 3 cycles, then high.
  - Required: no pulse, gate_a/gate_b stay 00.
  - Stimulus: low for 10 cycles.
  - Required: exactly one vec increment (gate_b=1), none on release.
- Vector wrap:
  - Stimulus: 4 qualified presses on but[0] in mode 0.
  - Required: {gate_a,gate_b} = 01,10,11,00; led[0] = 0,0,1,0, each 1 cycle after the operand update.
- Mode change restarts display:
  - Stimulus: press but[1] 3 times, the second during S_SHOW.
  - Required: led shows 01, then 10 with the timer restarted, then 11.
  - Stimulus: vec=10 in S_RUN.
  - Required: led[0]=NAND(1,0)=1.
- Simultaneous presses:
  - Stimulus: both buttons qualify in the same cycle from vec=00, mode=0.
  - Required: vec=01, mode=1, state S_SHOW, led=01.
- Auto-step (GATE_TEST_AUTO_STEP_EN defined):
  - Required: in S_RUN vec advances every 16 cycles.
  - Stimulus: manual press[0] coinciding with the auto tick.
  - Required: single increment.
  - Macro undefined: no change over 100 cycles.
